// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: opcodes, FSM states and decode helpers for alu_mdu.
// Optional macro ALU_MDU_DIV_EN adds DIV/DIVU to the multi-cycle set.
package alu_mdu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MULT  = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_MULTU = 4'b1110;
  localparam logic [3:0] OP_ILL   = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Ops that go through the iterative core instead of the 1-cycle path.
  function automatic logic is_multicycle(input logic [3:0] op);
`ifdef ALU_MDU_DIV_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative shift-add multiplier / restoring divider on magnitudes.
// The divider path exists only when ALU_MDU_DIV_EN is defined.
// hi/lo are combinational and hold the final values while the caller sits
// in its DONE cycle (the last iteration is folded into that cycle).
module mdu_iter
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             start,
  input  logic             step,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             last,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, m;
  logic             neg_q;
  logic             sgn;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   msum;
  logic [WIDTH-1:0] mhi, mlo;
  logic [2*WIDTH-1:0] prod, prod_s;
`ifdef ALU_MDU_DIV_EN
  logic             div_r, neg_r;
  logic [WIDTH:0]   rs, diff;
  logic [WIDTH-1:0] dhi, dlo;
`endif

  assign sgn   = (op == OP_MULT) || (op == OP_DIV);
  assign mag_a = (sgn && A[WIDTH-1]) ? -A : A;
  assign mag_b = (sgn && B[WIDTH-1]) ? -B : B;

  // One shift-add step: add multiplicand when the low multiplier bit is set.
  assign msum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m} : '0);
  assign mhi    = msum[WIDTH:1];
  assign mlo    = {msum[0], acc_lo[WIDTH-1:1]};
  assign prod   = {mhi, mlo};
  assign prod_s = neg_q ? -prod : prod;

`ifdef ALU_MDU_DIV_EN
  // One restoring-divide step: keep the trial difference if it did not borrow.
  assign rs   = {acc_hi, acc_lo[WIDTH-1]};
  assign diff = rs - {1'b0, m};
  assign dhi  = diff[WIDTH] ? rs[WIDTH-1:0] : diff[WIDTH-1:0];
  assign dlo  = {acc_lo[WIDTH-2:0], ~diff[WIDTH]};
`endif

  assign last = step && (cnt == CW'(WIDTH - 2));

  // Final values, with sign correction applied to the last-step result.
  always_comb begin
    hi = prod_s[2*WIDTH-1:WIDTH];
    lo = prod_s[WIDTH-1:0];
    if (dz) begin
      hi = acc_hi;
      lo = acc_lo;
    end
`ifdef ALU_MDU_DIV_EN
    else if (div_r) begin
      hi = neg_r ? -dhi : dhi;
      lo = neg_q ? -dlo : dlo;
    end
`endif
  end

  // Operand latch on start, one iteration per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      m      <= '0;
      neg_q  <= 1'b0;
      dz     <= 1'b0;
`ifdef ALU_MDU_DIV_EN
      div_r  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else if (flush) begin
      cnt <= '0;
      dz  <= 1'b0;
    end else if (start) begin
      cnt   <= '0;
      dz    <= 1'b0;
      neg_q <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
`ifdef ALU_MDU_DIV_EN
      div_r <= (op == OP_DIV) || (op == OP_DIVU);
      neg_r <= sgn && A[WIDTH-1];
      if ((op == OP_DIV) || (op == OP_DIVU)) begin
        m <= mag_b;
        if (B == '0) begin
          dz     <= 1'b1;
          acc_hi <= A;
          acc_lo <= '1;
        end else begin
          acc_hi <= '0;
          acc_lo <= mag_a;
        end
      end else
`endif
      begin
        acc_hi <= '0;
        acc_lo <= mag_b;
        m      <= mag_a;
      end
    end else if (step) begin
      cnt <= cnt + 1'b1;
`ifdef ALU_MDU_DIV_EN
      if (div_r) begin
        acc_hi <= dhi;
        acc_lo <= dlo;
      end else
`endif
      begin
        acc_hi <= mhi;
        acc_lo <= mlo;
      end
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with valid/ready handshake, registered result and
// an iterative multiply/divide unit writing HI/LO.
// Optional macro ALU_MDU_DIV_EN enables DIV/DIVU; otherwise they are illegal.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero_flag,
  output logic             overflow,
  output logic             div_by_zero,
  output logic             illegal_op,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  state_t           state;
  logic             accept, mc, ill, dz_req;
  logic [WIDTH-1:0] sum, dif, res;
  logic             ov;
  logic [SHW-1:0]   shamt;
  logic             mdu_last, mdu_dz;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;

  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign mc       = is_multicycle(alu_control);
`ifdef ALU_MDU_DIV_EN
  assign ill    = (alu_control == OP_ILL);
  assign dz_req = ((alu_control == OP_DIV) || (alu_control == OP_DIVU)) && (B == '0);
`else
  assign ill    = (alu_control == OP_ILL) || (alu_control == OP_DIV) || (alu_control == OP_DIVU);
  assign dz_req = 1'b0;
`endif

  assign sum   = A + B;
  assign dif   = A - B;
  assign shamt = B[SHW-1:0];

  // Single-cycle datapath; multi-cycle and illegal codes fall to result 0.
  always_comb begin
    res = '0;
    ov  = 1'b0;
    case (alu_control)
      OP_AND:  res = A & B;
      OP_OR:   res = A | B;
      OP_XOR:  res = A ^ B;
      OP_NOR:  res = ~(A | B);
      OP_ADD: begin
        res = sum;
        ov  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        res = dif;
        ov  = (A[WIDTH-1] != B[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT:  res = WIDTH'($signed(A) < $signed(B));
      OP_SLTU: res = WIDTH'(A < B);
      OP_SLL:  res = A << shamt;
      OP_SRL:  res = A >> shamt;
      OP_SRA:  res = WIDTH'($signed(A) >>> shamt);
      default: res = '0;
    endcase
  end

  mdu_iter #(.WIDTH(WIDTH)) u_mdu (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .start (accept && mc),
    .step  (state == ST_BUSY),
    .op    (alu_control),
    .A     (A),
    .B     (B),
    .last  (mdu_last),
    .dz    (mdu_dz),
    .hi    (mdu_hi),
    .lo    (mdu_lo)
  );

  // Control FSM and output registers; reset beats flush beats requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      out_valid   <= 1'b0;
      result      <= '0;
      zero_flag   <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
      illegal_op  <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (mc) begin
              state <= dz_req ? ST_DONE : ST_BUSY;
            end else begin
              out_valid   <= 1'b1;
              result      <= res;
              zero_flag   <= (res == '0);
              overflow    <= ov;
              div_by_zero <= 1'b0;
              illegal_op  <= ill;
            end
          end
        end
        ST_BUSY: if (mdu_last) state <= ST_DONE;
        ST_DONE: begin
          state       <= ST_IDLE;
          out_valid   <= 1'b1;
          hi          <= mdu_hi;
          lo          <= mdu_lo;
          result      <= mdu_lo;
          zero_flag   <= (mdu_lo == '0);
          overflow    <= 1'b0;
          div_by_zero <= mdu_dz;
          illegal_op  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
